// File: rtl/mic_pkg.sv
// Shared definitions for the MIC microsequencer: MIR field layout, NOP codes, FSM states.
package mic_pkg;

    localparam int unsigned MIR_W     = 31;
    localparam int unsigned NA_W      = 9;

    localparam int unsigned NA_MSB    = 30;
    localparam int unsigned NA_LSB    = 22;
    localparam int unsigned JMPC_BIT  = 21;
    localparam int unsigned JAMN_BIT  = 20;
    localparam int unsigned JAMZ_BIT  = 19;
    localparam int unsigned SHIFT_MSB = 18;
    localparam int unsigned SHIFT_LSB = 17;
    localparam int unsigned ALU_MSB   = 16;
    localparam int unsigned ALU_LSB   = 11;
    localparam int unsigned C_MSB     = 10;
    localparam int unsigned C_LSB     = 7;
    localparam int unsigned MEM_MSB   = 6;
    localparam int unsigned MEM_LSB   = 4;
    localparam int unsigned B_MSB     = 3;
    localparam int unsigned B_LSB     = 0;

    // Bit positions inside the 3-bit MEM field.
    localparam int unsigned MEM_WRITE = 2;
    localparam int unsigned MEM_READ  = 1;
    localparam int unsigned MEM_FETCH = 0;

    // Code 0 selects MAR, so NOP is the all-ones code.
    localparam logic [3:0] C_NOP = 4'hF;
    localparam logic [3:0] B_NOP = 4'hF;

    typedef enum logic [1:0] {
        S_RST,
        S_LOAD,
        S_EXEC,
        S_WAIT
    } seq_state_t;

endpackage

// File: rtl/mic_next_addr.sv
// Next-MPC computation: NEXT_ADDRESS ORed with the JAM condition bit and, for JMPC, MBR.
module mic_next_addr
    import mic_pkg::*;
(
    input  logic [NA_W-1:0] na_i,
    input  logic            jmpc_i,
    input  logic            jamn_i,
    input  logic            jamz_i,
    input  logic            n_i,
    input  logic            z_i,
    input  logic [7:0]      mbr_i,
    output logic [NA_W-1:0] next_addr_o
);

    // Pure OR, never an add: microcode relies on NA having zeros where MBR lands.
    always_comb begin
        next_addr_o[8]   = na_i[8] | (jamz_i & z_i) | (jamn_i & n_i);
        next_addr_o[7:0] = na_i[7:0] | (jmpc_i ? mbr_i : 8'h00);
    end

endmodule

// File: rtl/mic_sequenciador.sv
// MIC microsequencer: holds MPC and MIR, fetches from the control store, drives datapath fields.
module mic_sequenciador
    import mic_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 9,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] cs_addr,
    input  logic [MIR_W-1:0]  cs_data,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic [7:0]        mbr,
    input  logic              mem_ready,
    output logic [3:0]        controlC,
    output logic [3:0]        controlB,
    output logic [5:0]        alu_ctrl,
    output logic [1:0]        shift_ctrl,
    output logic              mem_write,
    output logic              mem_read,
    output logic              mem_fetch,
    output logic              commit
);

    seq_state_t        state_q, state_d;
    logic [MIR_W-1:0]  mir_q, mir_d;
    logic [ADDR_W-1:0] mpc_q, mpc_d;

    logic [NA_W-1:0] next_addr;
    logic [2:0]      mem_field;
    logic            active;
    logic            complete;

    assign mem_field = mir_q[MEM_MSB:MEM_LSB];
    assign active    = (state_q == S_EXEC) || (state_q == S_WAIT);
    // mem_ready only matters when this microinstruction actually touches memory.
    assign complete  = (mem_field == 3'b000) || mem_ready;

    mic_next_addr u_next_addr (
        .na_i        (mir_q[NA_MSB:NA_LSB]),
        .jmpc_i      (mir_q[JMPC_BIT]),
        .jamn_i      (mir_q[JAMN_BIT]),
        .jamz_i      (mir_q[JAMZ_BIT]),
        .n_i         (alu_n),
        .z_i         (alu_z),
        .mbr_i       (mbr),
        .next_addr_o (next_addr)
    );

    always_comb begin
        state_d = state_q;
        mir_d   = mir_q;
        mpc_d   = mpc_q;
        unique case (state_q)
            S_RST: state_d = S_LOAD;
            S_LOAD: begin
                mir_d   = cs_data;
                state_d = S_EXEC;
            end
            S_EXEC, S_WAIT: begin
                if (complete) begin
                    mpc_d   = ADDR_W'(next_addr);
                    state_d = S_LOAD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RST;
            mir_q   <= '0;
            mpc_q   <= RESET_ADDR;
        end else begin
            state_q <= state_d;
            mir_q   <= mir_d;
            mpc_q   <= mpc_d;
        end
    end

    assign cs_addr = mpc_q;

    always_comb begin
        controlC   = C_NOP;
        controlB   = B_NOP;
        alu_ctrl   = '0;
        shift_ctrl = '0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem_fetch  = 1'b0;
        if (active) begin
            controlC   = mir_q[C_MSB:C_LSB];
            controlB   = mir_q[B_MSB:B_LSB];
            alu_ctrl   = mir_q[ALU_MSB:ALU_LSB];
            shift_ctrl = mir_q[SHIFT_MSB:SHIFT_LSB];
            mem_write  = mem_field[MEM_WRITE];
            mem_read   = mem_field[MEM_READ];
            mem_fetch  = mem_field[MEM_FETCH];
        end
        // A reset edge aborts the cycle, so no register may latch on it.
        commit = active && complete && rst_n;
    end

endmodule

// File: tb/tb_mic_sequenciador.sv
// Directed self-checking bench for mic_sequenciador with a writable control-store model.
module tb_mic_sequenciador;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  cs_addr;
    logic [30:0] cs_data;
    logic        alu_n, alu_z;
    logic [7:0]  mbr;
    logic        mem_ready;
    logic [3:0]  controlC, controlB;
    logic [5:0]  alu_ctrl;
    logic [1:0]  shift_ctrl;
    logic        mem_write, mem_read, mem_fetch, commit;

    logic [30:0] rom [512];
    logic [8:0]  exp_addr;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    assign cs_data = rom[cs_addr];

    mic_sequenciador #(
        .ADDR_W     (9),
        .RESET_ADDR (9'h000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_addr    (cs_addr),
        .cs_data    (cs_data),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .mbr        (mbr),
        .mem_ready  (mem_ready),
        .controlC   (controlC),
        .controlB   (controlB),
        .alu_ctrl   (alu_ctrl),
        .shift_ctrl (shift_ctrl),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_fetch  (mem_fetch),
        .commit     (commit)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [30:0] mk_mi(input logic [8:0] na, input logic jmpc,
                                          input logic jamn, input logic jamz,
                                          input logic [1:0] sh, input logic [5:0] alu,
                                          input logic [3:0] c, input logic [2:0] mem,
                                          input logic [3:0] b);
        return {na, jmpc, jamn, jamz, sh, alu, c, mem, b};
    endfunction

    // Entered at a negedge in S_LOAD; k = cycles with mem_ready low before completion.
    task automatic run_uop(input string tag, input logic [30:0] mi, input logic n,
                           input logic z, input logic [7:0] m, input int k,
                           input logic [8:0] nxt);
        logic [2:0] mem;
        mem = mi[6:4];
        rom[exp_addr] = mi;
        check_eq({tag, ".load_addr"}, cs_addr, exp_addr);
        check_eq({tag, ".load_c"}, controlC, 4'hF);
        check_eq({tag, ".load_commit"}, commit, 1'b0);
        alu_n = n;
        alu_z = z;
        mbr = m;
        mem_ready = (mem != 3'b000) && (k == 0);
        @(negedge clk);
        check_eq({tag, ".exec_c"}, controlC, mi[10:7]);
        check_eq({tag, ".exec_b"}, controlB, mi[3:0]);
        check_eq({tag, ".exec_alu"}, alu_ctrl, mi[16:11]);
        check_eq({tag, ".exec_shift"}, shift_ctrl, mi[18:17]);
        for (int i = 0; i < k; i++) begin
            check_eq({tag, ".stall_commit"}, commit, 1'b0);
            check_eq({tag, ".stall_addr"}, cs_addr, exp_addr);
            check_eq({tag, ".stall_mem"}, {mem_write, mem_read, mem_fetch}, mem);
            @(negedge clk);
        end
        if (k > 0) begin
            mem_ready = 1'b1;
            #1;
        end
        check_eq({tag, ".done_commit"}, commit, 1'b1);
        check_eq({tag, ".done_mem"}, {mem_write, mem_read, mem_fetch}, mem);
        check_eq({tag, ".done_addr"}, cs_addr, exp_addr);
        @(negedge clk);
        mem_ready = 1'b0;
        exp_addr = nxt;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = '0;
        rst_n = 1'b0;
        alu_n = 1'b0;
        alu_z = 1'b0;
        mbr = 8'h00;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst.addr", cs_addr, 9'h000);
        check_eq("rst.c", controlC, 4'hF);
        check_eq("rst.b", controlB, 4'hF);
        check_eq("rst.strobes", {mem_write, mem_read, mem_fetch}, 3'b000);
        check_eq("rst.alu", alu_ctrl, 6'h00);
        check_eq("rst.commit", commit, 1'b0);

        rst_n = 1'b1;
        @(negedge clk);
        exp_addr = 9'h000;

        run_uop("lin0", mk_mi(9'h005, 0, 0, 0, 2'b01, 6'h3C, 4'h0, 3'b000, 4'h2),
                0, 0, 8'h00, 0, 9'h005);
        run_uop("lin5", mk_mi(9'h007, 0, 0, 0, 2'b10, 6'h35, 4'h3, 3'b000, 4'h4),
                0, 0, 8'h00, 0, 9'h007);
        run_uop("jamz1", mk_mi(9'h012, 0, 0, 1, 2'b00, 6'h14, 4'hF, 3'b000, 4'hF),
                0, 1, 8'h00, 0, 9'h112);
        run_uop("jamz0", mk_mi(9'h012, 0, 0, 1, 2'b00, 6'h14, 4'hF, 3'b000, 4'hF),
                0, 0, 8'h00, 0, 9'h012);
        run_uop("jamnz", mk_mi(9'h012, 0, 1, 1, 2'b00, 6'h14, 4'hF, 3'b000, 4'hF),
                1, 0, 8'h00, 0, 9'h112);
        run_uop("jmpc0", mk_mi(9'h000, 1, 0, 0, 2'b00, 6'h18, 4'h6, 3'b000, 4'h1),
                0, 0, 8'hA7, 0, 9'h0A7);
        run_uop("jmpc1", mk_mi(9'h100, 1, 0, 0, 2'b00, 6'h18, 4'h6, 3'b000, 4'h1),
                0, 0, 8'hA7, 0, 9'h1A7);
        run_uop("rdstall", mk_mi(9'h030, 0, 0, 0, 2'b00, 6'h3C, 4'h5, 3'b010, 4'h0),
                0, 0, 8'h00, 3, 9'h030);
        run_uop("wrnow", mk_mi(9'h040, 0, 0, 0, 2'b00, 6'h3C, 4'hF, 3'b100, 4'h7),
                0, 0, 8'h00, 0, 9'h040);

        // Reset while stalled in S_WAIT on a fetch.
        rom[exp_addr] = mk_mi(9'h055, 0, 0, 0, 2'b00, 6'h35, 4'h2, 3'b001, 4'h3);
        check_eq("rstw.load_addr", cs_addr, 9'h040);
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("rstw.exec_fetch", mem_fetch, 1'b1);
        @(negedge clk);
        check_eq("rstw.wait_fetch", mem_fetch, 1'b1);
        check_eq("rstw.wait_commit", commit, 1'b0);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_eq("rstw.abort_commit", commit, 1'b0);
        @(negedge clk);
        check_eq("rstw.addr", cs_addr, 9'h000);
        check_eq("rstw.c", controlC, 4'hF);
        check_eq("rstw.b", controlB, 4'hF);
        check_eq("rstw.strobes", {mem_write, mem_read, mem_fetch}, 3'b000);
        check_eq("rstw.commit", commit, 1'b0);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mic_sequenciador.md
# mic_sequenciador

Microsequencer for the MIC datapath. It holds MPC and MIR, fetches microinstructions from an external control store, and drives the encoded field outputs. Its 4-bit C field output feeds `DecodificadorC`, and the B, ALU, shift and memory fields go to the matching datapath stages. It computes the next MPC from NEXT_ADDRESS, the JAM bits, the latched N/Z flags and MBR, and stretches execution while memory is busy.

## Interface
Parameters:
- `ADDR_W`, 9: control-store address width (MPC).
- `RESET_ADDR`, 9'h000: MPC value after reset.

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `cs_addr`, out, 9: control-store address, equals MPC.
- `cs_data`, in, 31: microinstruction; combinational read of `cs_addr`, valid the same cycle.
- `alu_n`, in, 1: ALU negative flag.
- `alu_z`, in, 1: ALU zero flag.
- `mbr`, in, 8: MBR contents, used by JMPC.
- `mem_ready`, in, 1: memory has completed the requested read, write or fetch.
- `controlC`, out, 4: encoded C-bus destination to the C decoder.
- `controlB`, out, 4: encoded B-bus source.
- `alu_ctrl`, out, 6: ALU function (F0 F1 ENA ENB INVA INC).
- `shift_ctrl`, out, 2: SLL8/SRA1.
- `mem_write`, out, 1: memory write strobe.
- `mem_read`, out, 1: memory read strobe.
- `mem_fetch`, out, 1: memory fetch strobe.
- `commit`, out, 1: high on the single cycle when datapath registers latch the C bus.

## Operation
- MIR layout, MSB to LSB: NEXT_ADDRESS[30:22], JMPC[21], JAMN[20], JAMZ[19], SHIFT[18:17], ALU[16:11], C[10:7], MEM[6:4] (WRITE, READ, FETCH), B[3:0].
- NOP encodings: C = 4'hF and B = 4'hF. Code 0 is a real destination (MAR), so an all-zero MIR is never a NOP.
- FSM states: `S_RST`, `S_LOAD`, `S_EXEC`, `S_WAIT`.
  - `S_RST` is entered while `rst_n`=0, then goes to `S_LOAD`.
  - `S_LOAD`: MIR <= `cs_data`. Go to `S_EXEC`.
  - `S_EXEC`: the MIR fields drive the outputs. If MEM≠0 and `mem_ready`=0, go to `S_WAIT`. Otherwise assert `commit`, sample N/Z/MBR, update MPC, and go to `S_LOAD`.
  - `S_WAIT`: outputs are held from MIR. Stay until `mem_ready`=1, then behave exactly as the completing cycle of `S_EXEC`.
- Next address (9 bits, no carry, pure OR):
  - MPC[8] = NA[8] | (JAMZ & Z) | (JAMN & N).
  - MPC[7:0] = NA[7:0] | (JMPC ? MBR : 8'h00).
- N/Z and MBR are sampled on the completing cycle of the current microinstruction. JAMN and JAMZ may both be set.
- In `S_RST` and `S_LOAD`, outputs are forced to NOP: C = 4'hF, B = 4'hF, ALU = 0, SHIFT = 0, memory strobes 0, `commit` = 0.
- MEM strobes are level outputs, held through `S_EXEC` and `S_WAIT` until completion.

## Timing
- Reset values, applied on the first edge with `rst_n`=0:
  - MPC = RESET_ADDR, MIR = 0 (internal), state = `S_RST`.
  - All outputs at NOP values; `cs_addr` = RESET_ADDR.
- Throughput: 2 cycles per microinstruction without memory, 2+k cycles with k wait cycles.
- `mem_ready` is sampled only in `S_EXEC` and `S_WAIT`, and is ignored when MEM = 0.
- If `mem_ready` is already 1 in `S_EXEC`, there is no `S_WAIT`.
- `rst_n`=0 in any state, including `S_WAIT`, aborts immediately at the next edge. No commit happens in that cycle.
- `cs_addr` changes only on the edge that ends the completing cycle and is stable during `S_LOAD`.

## Structure
- Shared package `mic_pkg`:
  - MIR field bit positions and widths.
  - `C_NOP` and `B_NOP` constants.
  - State enum `seq_state_t`.
  - MEM bit indices.
- Sub-module `mic_next_addr`: combinational next-MPC logic (NA, JAM, N, Z, MBR in; 9-bit address out).

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → `cs_addr`=0, `controlC`=4'hF, `controlB`=4'hF, strobes 0, `commit` 0; the first `S_EXEC` happens at cycle 2 after release.
- Linear flow: ROM[0]: NA=5, C=0, B=2; ROM[5]: NA=7 → `controlC`=0 during EXEC with `commit`=1, then `cs_addr`=5, then 7, with 2-cycle spacing.
- Conditional: NA=0x012, JAMZ=1, `alu_z`=1 → next `cs_addr`=0x112. Repeat with `alu_z`=0 → 0x012. Both JAMN and JAMZ set with N=1, Z=0 → 0x112.
- JMPC: NA=0x000, JMPC=1, `mbr`=8'hA7 → next `cs_addr`=0x0A7. With NA=0x100 → 0x1A7.
- Memory stall: MEM=READ, `mem_ready` low for 3 cycles → `mem_read` held 4 cycles, `commit` only on the last, and MPC unchanged until then.
- Reset during `S_WAIT` → no `commit` pulse; the next edge gives `cs_addr`=RESET_ADDR and NOP outputs.
